// File: rtl/request_unit.sv
// request_unit
//   Sequences memory requests for the single-cycle MIPS datapath. It turns the
//   control unit's level decode signals into an instruction-fetch / data-access
//   handshake with the memory controller. It also produces the PC advance
//   strobe, latches halt, and counts stall cycles.
//
//   Optional feature macro: REQ_TIMEOUT_EN
//     When defined, a per-request watchdog forces HALT and sets a sticky
//     timeout flag after TIMEOUT_CYC cycles without the expected hit.
//     When undefined, timeout is tied to 0.
//
// Ports:
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   iread      in   instruction fetch wanted (0 on HALT opcode)
//   dread      in   load decoded
//   dwrite     in   store decoded
//   halt       in   halt decoded
//   ihit       in   instruction word valid this cycle
//   dhit       in   data access completed this cycle
//   imemREN    out  instruction read request (combinational)
//   dmemREN    out  data read request (registered)
//   dmemWEN    out  data write request (registered)
//   pc_en      out  one-cycle PC advance strobe (combinational)
//   halted     out  sticky halt indication
//   stall_cnt  out  saturating count of cycles spent waiting on ihit/dhit
//   timeout    out  sticky watchdog flag
module request_unit #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iread,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_dmem_ren;
    logic             r_dmem_wen;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_stall;
    logic w_wd_expire;

    if (TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("request_unit: TIMEOUT_CYC must be at least 1");
    end

    // Waiting on the hit that matters in the current state.
    assign w_stall = ((r_state == FETCH) && !ihit) || ((r_state == DATA) && !dhit);

    // pc_en is gated by nRST so an async reset mid-access never yields a strobe.
    always_comb begin
        imemREN = (r_state == FETCH);
        pc_en   = nRST &&
                  (((r_state == FETCH) && ihit && iread && !halt && !dread && !dwrite) ||
                   ((r_state == DATA) && dhit));
    end

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;

    // Any hit ends the current request, so it also restarts the watchdog;
    // this covers every state entry out of FETCH/DATA.
    assign w_wd_expire = w_stall && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == HALT) begin
            r_wdog <= '0;
        end else if (w_stall) begin
            r_wdog <= r_wdog + 1'b1;
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wdog <= '0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= FETCH;
            r_dmem_ren  <= 1'b0;
            r_dmem_wen  <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            unique case (r_state)
                FETCH: begin
                    if (w_wd_expire) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (ihit) begin
                        if (halt || !iread) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else if (dread || dwrite) begin
                            // Write wins when both are decoded.
                            r_state    <= DATA;
                            r_dmem_wen <= dwrite;
                            r_dmem_ren <= dread && !dwrite;
                        end
                    end
                end
                DATA: begin
                    if (w_wd_expire) begin
                        r_state    <= HALT;
                        r_halted   <= 1'b1;
                        r_dmem_ren <= 1'b0;
                        r_dmem_wen <= 1'b0;
                    end else if (dhit) begin
                        r_state    <= FETCH;
                        r_dmem_ren <= 1'b0;
                        r_dmem_wen <= 1'b0;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign dmemREN   = r_dmem_ren;
    assign dmemWEN   = r_dmem_wen;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_request_unit.sv
// Directed and randomized checking of request_unit against a behavioural
// model of the request sequencing rules. Build with or without
// REQ_TIMEOUT_EN; the model follows the same macro.
module tb_request_unit;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TO_CYC  = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_FETCH = 0;
    localparam int M_DATA  = 1;
    localparam int M_HALT  = 2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             iread, dread, dwrite, halt, ihit, dhit;
    logic             imemREN, dmemREN, dmemWEN, pc_en, halted, timeout;
    logic [CNT_W-1:0] stall_cnt;

    always #5 CLK = ~CLK;

    request_unit #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iread     (iread),
        .dread     (dread),
        .dwrite    (dwrite),
        .halt      (halt),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pc_en     (pc_en),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .timeout   (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_phase;
    int m_cnt;
    int m_wd;
    bit m_ren, m_wen, m_halted, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = M_FETCH;
        m_cnt    = 0;
        m_wd     = 0;
        m_ren    = 0;
        m_wen    = 0;
        m_halted = 0;
        m_to     = 0;
    endtask

    task automatic drive_random();
        iread  = ($urandom_range(15, 0) != 0);
        dread  = ($urandom_range(3, 0) == 0);
        dwrite = ($urandom_range(3, 0) == 0);
        halt   = ($urandom_range(63, 0) == 0);
        ihit   = $urandom_range(1, 0) == 1;
        dhit   = $urandom_range(1, 0) == 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imemREN"}, imemREN, 1);
        chk({tag, "_dmemREN"}, dmemREN, 0);
        chk({tag, "_dmemWEN"}, dmemWEN, 0);
        chk({tag, "_pc_en"}, pc_en, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Reset held for several cycles with random inputs; released by the next step.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive_random();
        #1;
        model_reset();
        check_reset_outputs("rst");
        repeat (3) begin
            @(negedge CLK);
            drive_random();
            #1;
            check_reset_outputs("rst_hold");
        end
    endtask

    // One clock: drive inputs at negedge, compare, then advance the model
    // to what the following rising edge should produce.
    task automatic step(input bit ir, input bit dr, input bit dw, input bit h,
                        input bit ih, input bit dh);
        bit stalled;
        bit exp_pc;
        @(negedge CLK);
        nRST   = 1'b1;
        iread  = ir;
        dread  = dr;
        dwrite = dw;
        halt   = h;
        ihit   = ih;
        dhit   = dh;
        #1;
        exp_pc = ((m_phase == M_FETCH) && ih && ir && !h && !dr && !dw) ||
                 ((m_phase == M_DATA) && dh);
        chk("imemREN", imemREN, (m_phase == M_FETCH));
        chk("pc_en", pc_en, exp_pc);
        chk("dmemREN", dmemREN, m_ren);
        chk("dmemWEN", dmemWEN, m_wen);
        chk("halted", halted, m_halted);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("timeout", timeout, m_to);

        stalled = ((m_phase == M_FETCH) && !ih) || ((m_phase == M_DATA) && !dh);
        if (stalled && (m_cnt < CNT_MAX)) m_cnt++;

        if (m_phase == M_FETCH && ih) begin
            if (h || !ir) begin
                m_phase  = M_HALT;
                m_halted = 1;
            end else if (dr || dw) begin
                m_phase = M_DATA;
                m_wen   = dw;
                m_ren   = dr && !dw;
            end
        end else if (m_phase == M_DATA && dh) begin
            m_phase = M_FETCH;
            m_ren   = 0;
            m_wen   = 0;
        end
`ifdef REQ_TIMEOUT_EN
        if (stalled) begin
            m_wd++;
            if (m_wd == TO_CYC) begin
                m_phase  = M_HALT;
                m_halted = 1;
                m_to     = 1;
                m_ren    = 0;
                m_wen    = 0;
                m_wd     = 0;
            end
        end else begin
            m_wd = 0;
        end
`endif
    endtask

    // Async reset in the middle of a cycle while a data access is pending,
    // with inputs that would otherwise complete it.
    task automatic mid_access_reset();
        iread  = 1'b1;
        dread  = 1'b0;
        dwrite = 1'b0;
        halt   = 1'b0;
        ihit   = 1'b1;
        dhit   = 1'b1;
        #1;
        nRST = 1'b0;
        #1;
        chk("midrst_dmemREN", dmemREN, 0);
        chk("midrst_dmemWEN", dmemWEN, 0);
        chk("midrst_pc_en", pc_en, 0);
        chk("midrst_imemREN", imemREN, 1);
        model_reset();
    endtask

    initial begin
        nRST   = 1'b0;
        iread  = 1'b0;
        dread  = 1'b0;
        dwrite = 1'b0;
        halt   = 1'b0;
        ihit   = 1'b0;
        dhit   = 1'b0;
        model_reset();

        // Reset and release
        do_reset();
        step(1, 0, 0, 0, 0, 0);

        // ALU stream
        do_reset();
        repeat (5) step(1, 0, 0, 0, 1, 0);
        chk("alu_pc_en", pc_en, 1);
        chk("alu_stall_cnt", stall_cnt, 0);

        // Load with three wait cycles
        step(1, 1, 0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        chk("load_dmemREN", dmemREN, 1);
        chk("load_imemREN", imemREN, 0);
        step(1, 1, 0, 0, 0, 1);
        chk("load_pc_en_dhit", pc_en, 1);
        step(1, 0, 0, 0, 1, 0);
        chk("load_stall_cnt", stall_cnt, 3);

        // Conflicting decode: write wins
        step(1, 1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("conflict_wen", dmemWEN, 1);
        chk("conflict_ren", dmemREN, 0);
        step(1, 1, 1, 0, 0, 1);

        // Reset during a pending store
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        mid_access_reset();
        step(1, 0, 0, 0, 1, 0);

        // Halt is absorbing
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        chk("halt_halted", halted, 1);
        chk("halt_imemREN", imemREN, 0);
        chk("halt_pc_en", pc_en, 0);
        repeat (4) step(1, 1, 1, 0, 1, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        chk("halt_stall_frozen", stall_cnt, 1);

        // Hung instruction memory: watchdog or saturation
        do_reset();
        repeat (8) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
`ifdef REQ_TIMEOUT_EN
        chk("wd_timeout", timeout, 1);
        chk("wd_halted", halted, 1);
        chk("wd_stall_cnt", stall_cnt, 8);
`else
        chk("nowd_timeout", timeout, 0);
        chk("nowd_stall_cnt", stall_cnt, 8);
        chk("nowd_imemREN", imemREN, 1);
`endif
        repeat (30) step(1, 0, 0, 0, 0, 0);
`ifdef REQ_TIMEOUT_EN
        chk("wd_frozen", stall_cnt, 8);
`else
        chk("sat_stall_cnt", stall_cnt, CNT_MAX);
`endif

        // Randomized segments
        repeat (4) begin
            do_reset();
            repeat (150) begin
                step(($urandom_range(15, 0) != 0), ($urandom_range(3, 0) == 0),
                     ($urandom_range(3, 0) == 0), ($urandom_range(63, 0) == 0),
                     ($urandom_range(1, 0) == 1), ($urandom_range(1, 0) == 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
